// File: rtl/rx_pkg.sv
// Shared constants and types for the UART receive-buffer path.
package rx_pkg;
   localparam int RX_DATA_WIDTH = 8;
   localparam int RX_FIFO_DEPTH = 4;

   typedef logic [RX_DATA_WIDTH-1:0] rx_byte_t;
endpackage : rx_pkg

// File: rtl/rx_fifo_ctrl_if.sv
// Receiver/host handshake bundle for the receive FIFO controller.
interface rx_fifo_ctrl_if
   import rx_pkg::*;
#(
   parameter int DATA_WIDTH = RX_DATA_WIDTH,
   parameter int DEPTH      = RX_FIFO_DEPTH
);
   logic                     load_buffer;
   logic [DATA_WIDTH-1:0]    rx_packet_data;
   logic                     data_read;
   logic                     fifo_clear;
   logic [DATA_WIDTH-1:0]    rx_data;
   logic                     data_ready;
   logic                     overrun_error;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output load_buffer, rx_packet_data, data_read, fifo_clear,
      input  rx_data, data_ready, overrun_error, count
   );

   modport slave (
      input  load_buffer, rx_packet_data, data_read, fifo_clear,
      output rx_data, data_ready, overrun_error, count
   );
endinterface : rx_fifo_ctrl_if

// File: rtl/rx_fifo_mem.sv
// DEPTH x DATA_WIDTH register file: synchronous write, combinational read.
module rx_fifo_mem
   import rx_pkg::*;
#(
   parameter int DATA_WIDTH = RX_DATA_WIDTH,
   parameter int DEPTH      = RX_FIFO_DEPTH
) (
   input  logic                       clk,
   input  logic                       wen,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]      wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]      rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: storage carries no reset; the controller's count masks stale entries.
   always_ff @(posedge clk) begin
      if (wen) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule : rx_fifo_mem

// File: rtl/rx_fifo_ctrl.sv
// Receive-buffer controller: circular FIFO with occupancy count, sticky overrun and flush.
module rx_fifo_ctrl
   import rx_pkg::*;
#(
   parameter int DATA_WIDTH = RX_DATA_WIDTH,
   parameter int DEPTH      = RX_FIFO_DEPTH
) (
   input  logic           clk,
   input  logic           n_rst,
   rx_fifo_ctrl_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [CW-1:0]          count_q;
   logic                   overrun_q;
   logic                   full, empty, push_ok, pop_ok, drop;
   logic                   mem_wen;
   logic [DATA_WIDTH-1:0]  head;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      full    = 1'b0;
      empty   = 1'b0;
      push_ok = 1'b0;
      pop_ok  = 1'b0;
      drop    = 1'b0;
      full    = (count_q == CW'(DEPTH));
      empty   = (count_q == '0);
      pop_ok  = bus.data_read && !empty;
      // A pop at full frees the slot the incoming byte needs.
      push_ok = bus.load_buffer && (!full || bus.data_read);
      drop    = bus.load_buffer && full && !bus.data_read;
   end

   assign mem_wen = push_ok && !bus.fifo_clear && n_rst;

   rx_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk   (clk),
      .wen   (mem_wen),
      .waddr (wr_ptr),
      .wdata (bus.rx_packet_data),
      .raddr (rd_ptr),
      .rdata (head)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else if (bus.fifo_clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (drop)        overrun_q <= 1'b1;
         else if (pop_ok) overrun_q <= 1'b0;
      end
   end

   assign bus.count         = count_q;
   assign bus.data_ready    = !empty;
   assign bus.overrun_error = overrun_q;
   assign bus.rx_data       = empty ? '0 : head;
endmodule : rx_fifo_ctrl

// File: tb/tb_rx_fifo_ctrl.sv
// Directed self-checking bench for rx_fifo_ctrl.
module tb_rx_fifo_ctrl;
   import rx_pkg::*;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   rx_fifo_ctrl_if bus ();

   rx_fifo_ctrl dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
      bus.load_buffer = 1'b0;
      bus.data_read   = 1'b0;
      bus.fifo_clear  = 1'b0;
   endtask

   task automatic push(input rx_byte_t b);
      bus.load_buffer    = 1'b1;
      bus.rx_packet_data = b;
      tick();
   endtask

   task automatic pop();
      bus.data_read = 1'b1;
      tick();
   endtask

   task automatic fill4();
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
   endtask

   rx_byte_t exp_q [4];

   initial begin
      bus.load_buffer    = 1'b0;
      bus.rx_packet_data = '0;
      bus.data_read      = 1'b0;
      bus.fifo_clear     = 1'b0;

      // 1. Reset with push and pop requests active
      n_rst = 1'b0;
      bus.load_buffer    = 1'b1;
      bus.data_read      = 1'b1;
      bus.rx_packet_data = 8'hFF;
      @(posedge clk); @(posedge clk); #1;
      n_rst = 1'b1;
      bus.load_buffer = 1'b0;
      bus.data_read   = 1'b0;
      check("rst_ready",   32'(bus.data_ready),    32'd0);
      check("rst_count",   32'(bus.count),         32'd0);
      check("rst_overrun", 32'(bus.overrun_error), 32'd0);
      check("rst_rx_data", 32'(bus.rx_data),       32'h00);

      // 2. Single byte
      push(8'hA5);
      check("single_ready", 32'(bus.data_ready), 32'd1);
      check("single_data",  32'(bus.rx_data),    32'hA5);
      check("single_count", 32'(bus.count),      32'd1);
      pop();
      check("single_pop_count", 32'(bus.count),      32'd0);
      check("single_pop_ready", 32'(bus.data_ready), 32'd0);
      check("single_pop_data",  32'(bus.rx_data),    32'h00);
      pop();
      check("empty_pop_count",   32'(bus.count),         32'd0);
      check("empty_pop_ready",   32'(bus.data_ready),    32'd0);
      check("empty_pop_overrun", 32'(bus.overrun_error), 32'd0);

      // 3. Overrun
      fill4();
      check("full_overrun_pre", 32'(bus.overrun_error), 32'd0);
      push(8'h55);
      check("ovr_count", 32'(bus.count),         32'd4);
      check("ovr_flag",  32'(bus.overrun_error), 32'd1);
      check("ovr_head",  32'(bus.rx_data),       32'h11);
      exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovr_read%0d", i), 32'(bus.rx_data), 32'(exp_q[i]));
         pop();
         check($sformatf("ovr_cnt%0d", i), 32'(bus.count), 32'(3 - i));
         check($sformatf("ovr_flag%0d", i), 32'(bus.overrun_error), 32'd0);
      end
      check("ovr_drain_data", 32'(bus.rx_data), 32'h00);

      // 4. Full with simultaneous push and pop
      fill4();
      bus.data_read = 1'b1;
      push(8'h66);
      check("fullpp_count",   32'(bus.count),         32'd4);
      check("fullpp_overrun", 32'(bus.overrun_error), 32'd0);
      exp_q = '{8'h22, 8'h33, 8'h44, 8'h66};
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fullpp_read%0d", i), 32'(bus.rx_data), 32'(exp_q[i]));
         pop();
      end
      check("fullpp_empty", 32'(bus.count), 32'd0);

      // 5. Wrap-around
      for (int k = 1; k <= 10; k++) begin
         push(rx_byte_t'(k));
         check($sformatf("wrap_cnt%0d", k),  32'(bus.count),   32'd1);
         check($sformatf("wrap_data%0d", k), 32'(bus.rx_data), 32'(k));
         pop();
         check($sformatf("wrap_empty%0d", k), 32'(bus.count), 32'd0);
      end

      // 6. Flush and reset mid-stream
      push(8'h31); push(8'h32); push(8'h33);
      check("flush_pre_count", 32'(bus.count), 32'd3);
      bus.fifo_clear = 1'b1;
      push(8'h99);
      check("flush_count",   32'(bus.count),      32'd0);
      check("flush_ready",   32'(bus.data_ready), 32'd0);
      check("flush_rx_data", 32'(bus.rx_data),    32'h00);
      fill4();
      push(8'h55);
      check("flush_ovr_set", 32'(bus.overrun_error), 32'd1);
      bus.fifo_clear = 1'b1;
      tick();
      check("flush_ovr_clr", 32'(bus.overrun_error), 32'd0);
      check("flush_ovr_cnt", 32'(bus.count),         32'd0);
      push(8'h41); push(8'h42);
      check("refill_count", 32'(bus.count),   32'd2);
      check("refill_head",  32'(bus.rx_data), 32'h41);
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      check("midrst_count",   32'(bus.count),         32'd0);
      check("midrst_overrun", 32'(bus.overrun_error), 32'd0);
      check("midrst_ready",   32'(bus.data_ready),    32'd0);
      push(8'h77);
      check("post_rst_data", 32'(bus.rx_data), 32'h77);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule : tb_rx_fifo_ctrl
